branch_ctrl_unit: RTL and testbench
===================================

Name: branch_ctrl_unit

Overview:
- Control stage that drives the fetch unit's start/start_addr/branch/target/taken/halt inputs.
- Consumes the instruction at the current PC from the instruction ROM and the ALU flags.
- Sequences program launch and halt, resolves branches against registered flags through a constant branch-target LUT, and counts executed cycles.
- Sits between the instruction ROM/ALU and the fetch unit.

Parameters:
INST_W, 9, instruction word width
CNT_W, 16, cycle counter width
TIMEOUT, 16'hFFFF, RUN cycle limit before forced halt

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
go  in  1  request to launch program; single-cycle pulse or level
prog_base  in  8  program start address, sampled on accepted go
inst  in  INST_W  instruction at current fetch PC; combinational ROM output, valid same cycle
alu_zero  in  1  ALU result zero
alu_neg  in  1  ALU result negative
flag_we  in  1  update flag register from alu_zero/alu_neg
start  out  1  to fetch unit: load start_addr
start_addr  out  8  to fetch unit: launch address
branch  out  1  current instruction is a branch/jump
target  out  8  branch target address
taken  out  1  branch taken this cycle
halt  out  1  processor halted or idle
done  out  1  program finished via HALT instruction
timeout  out  1  program stopped by TIMEOUT
cycle_cnt  out  CNT_W  RUN cycles of last/current program

Behaviour:
- States: IDLE, LAUNCH, RUN, HALTED. Registered state, base_q[7:0], zero_q, neg_q, cycle_cnt, done, timeout.
- Reset (async, rst_n=0), all values forced immediately:
  - State=IDLE; base_q=0; flags=0; cycle_cnt=0; done=0; timeout=0.
  - Outputs: start=1, start_addr=0, branch=0, taken=0, target=0, halt=1.
- Decode: opcode=inst[8:5], idx=inst[3:0].
  - 4'b1100 BZ, 4'b1101 BN, 4'b1110 JMP, 4'b1111 HALT; all others are non-control.
  - target = BR_LUT[idx] whenever opcode is BZ/BN/JMP, else 0.
- IDLE:
  - Outputs: start=1, start_addr=base_q, halt=1.
  - go=1: base_q<=prog_base, go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - Outputs: start=1, start_addr=base_q, halt=0.
  - Clear flags, cycle_cnt, done, timeout; go to RUN.
  - Next cycle the fetch PC equals base_q.
- RUN:
  - start=0, halt=0. Outputs combinational from inst and registered flags, zero added latency.
  - branch=1 for BZ/BN/JMP.
  - taken=1 for JMP, for BZ when zero_q=1, for BN when neg_q=1.
  - flag_we=1: zero_q/neg_q load at clock edge. A branch in the same cycle uses the old flags.
  - cycle_cnt increments every RUN cycle, including the HALT cycle.
  - HALT opcode: halt=1 combinationally that cycle, branch=taken=0; done<=1; go to HALTED.
  - cycle_cnt==TIMEOUT-1 at an edge without HALT: timeout<=1; go to HALTED. HALT in that same cycle takes priority (done=1, timeout=0).
  - go ignored.
- HALTED:
  - halt=1, start=0, branch=taken=0. cycle_cnt, done, timeout held.
  - go=1: base_q<=prog_base, go to LAUNCH.
- cycle_cnt saturates at all-ones; it never wraps.
- Target 8'hFF is legal. Fetch PC wrap from 8'hFF to 8'h00 is not this block's concern.
- Reset mid-RUN: immediate return to IDLE values; no partial counts retained.

Decomposition:
- Package branch_pkg:
  - state enum.
  - opcode constants OP_BZ/OP_BN/OP_JMP/OP_HALT.
  - BR_LUT as 16-entry 8-bit constant array: entry i = 8'h10*i, entry 15 = 8'hFF.
- Sub-module br_decode: combinational inst + flags -> branch/taken/target/is_halt.
- FSM and counter stay in the top module.

Test Plan:
- Reset then idle, go=0 for 5 cycles -> start=1, start_addr=0, halt=1, cycle_cnt=0, taken=0.
- go with prog_base=8'h20 -> LAUNCH: start=1, start_addr=8'h20. Next cycle RUN: start=0, halt=0; cycle_cnt counts 1,2,3.
- RUN: flag_we=1, alu_zero=1; next cycle inst=BZ idx 3 -> branch=1, taken=1, target=8'h30. Same-cycle flag_we, alu_zero=0 -> taken still 1; following BZ -> taken=0.
- RUN: inst=JMP idx 15 -> taken=1, target=8'hFF. inst=BN idx 2 with neg_q=0 -> branch=1, taken=0, target=8'h20.
- HALT after 7 RUN cycles -> halt=1 that cycle; then HALTED, done=1, cycle_cnt=7. go with prog_base=8'h40 -> relaunch, cycle_cnt clears to 0, done=0.
- TIMEOUT=10, no HALT -> after 10 RUN cycles HALTED, timeout=1, done=0, cycle_cnt=10. Separately, rst_n low mid-RUN -> immediate IDLE values.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch control unit: FSM states, control opcodes, branch-target table.
package branch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [3:0] OP_BZ   = 4'b1100;
  localparam logic [3:0] OP_BN   = 4'b1101;
  localparam logic [3:0] OP_JMP  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // Entry i is 8'h10*i, except the last which points at the top of the address space.
  localparam logic [7:0] BR_LUT [0:15] = '{
    8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70,
    8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hFF
  };

endpackage

// File: rtl/branch_ctrl_unit_decode.sv
// Purely combinational control-opcode decode; resolves taken against the registered flags.
module br_decode
  import branch_pkg::*;
#(
  parameter int INST_W = 9
) (
  input  logic [INST_W-1:0] inst,
  input  logic              zero_q,
  input  logic              neg_q,
  output logic              branch,
  output logic              taken,
  output logic [7:0]        target,
  output logic              is_halt
);

  logic [3:0] w_opcode;
  logic [3:0] w_idx;
  logic       w_unused_bit;

  assign w_opcode     = inst[8:5];
  assign w_idx        = inst[3:0];
  assign w_unused_bit = inst[4];

  always_comb begin
    branch  = 1'b0;
    taken   = 1'b0;
    target  = 8'h00;
    is_halt = 1'b0;
    case (w_opcode)
      OP_BZ: begin
        branch = 1'b1;
        taken  = zero_q;
        target = BR_LUT[w_idx];
      end
      OP_BN: begin
        branch = 1'b1;
        taken  = neg_q;
        target = BR_LUT[w_idx];
      end
      OP_JMP: begin
        branch = 1'b1;
        taken  = 1'b1;
        target = BR_LUT[w_idx];
      end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_ctrl_unit.sv
// Launch/run/halt sequencer for the fetch unit with flag register and saturating RUN-cycle counter.
module branch_ctrl_unit
  import branch_pkg::*;
#(
  parameter int                INST_W  = 9,
  parameter int                CNT_W   = 16,
  parameter logic [CNT_W-1:0]  TIMEOUT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [7:0]        prog_base,
  input  logic [INST_W-1:0] inst,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic              flag_we,
  output logic              start,
  output logic [7:0]        start_addr,
  output logic              branch,
  output logic [7:0]        target,
  output logic              taken,
  output logic              halt,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_cnt
);

  state_t           r_state;
  logic [7:0]       r_base;
  logic             r_zero;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_timeout;

  logic             w_branch;
  logic             w_taken;
  logic [7:0]       w_target;
  logic             w_is_halt;
  logic             w_run;
  logic [CNT_W-1:0] w_limit;

  assign w_run   = (r_state == ST_RUN);
  assign w_limit = TIMEOUT - 1'b1;

  br_decode #(.INST_W(INST_W)) u_decode (
    .inst    (inst),
    .zero_q  (r_zero),
    .neg_q   (r_neg),
    .branch  (w_branch),
    .taken   (w_taken),
    .target  (w_target),
    .is_halt (w_is_halt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_base    <= 8'h00;
      r_zero    <= 1'b0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALTED: begin
          if (go) begin
            r_base  <= prog_base;
            r_state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_zero    <= 1'b0;
          r_neg     <= 1'b0;
          r_cnt     <= '0;
          r_done    <= 1'b0;
          r_timeout <= 1'b0;
          r_state   <= ST_RUN;
        end
        ST_RUN: begin
          if (flag_we) begin
            r_zero <= alu_zero;
            r_neg  <= alu_neg;
          end
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          // HALT wins over a coincident timeout so a program finishing on the last cycle reports done.
          if (w_is_halt) begin
            r_done  <= 1'b1;
            r_state <= ST_HALTED;
          end else if (r_cnt == w_limit) begin
            r_timeout <= 1'b1;
            r_state   <= ST_HALTED;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    start = 1'b0;
    halt  = 1'b1;
    case (r_state)
      ST_IDLE:   begin start = 1'b1; halt = 1'b1; end
      ST_LAUNCH: begin start = 1'b1; halt = 1'b0; end
      ST_RUN:    begin start = 1'b0; halt = w_is_halt; end
      default:   begin start = 1'b0; halt = 1'b1; end
    endcase
  end

  assign start_addr = r_base;
  assign branch     = w_run & w_branch;
  assign taken      = w_run & w_taken;
  assign target     = w_run ? w_target : 8'h00;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign cycle_cnt  = r_cnt;

endmodule

// File: tb/tb_branch_ctrl_unit.sv
// Directed bench for branch_ctrl_unit, built with a short TIMEOUT so the forced-halt path is reachable.
module tb_branch_ctrl_unit;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             go;
  logic [7:0]       prog_base;
  logic [8:0]       inst;
  logic             alu_zero, alu_neg, flag_we;
  logic             start, branch, taken, halt, done, timeout;
  logic [7:0]       start_addr, target;
  logic [CNT_W-1:0] cycle_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // {start, halt, branch, taken, done, timeout, start_addr, target}
  logic [21:0] obs;
  assign obs = {start, halt, branch, taken, done, timeout, start_addr, target};

  localparam logic [8:0] I_NOP  = 9'b0000_0_0000;
  localparam logic [8:0] I_BZ3  = 9'b1100_0_0011;
  localparam logic [8:0] I_BN2  = 9'b1101_0_0010;
  localparam logic [8:0] I_JMPF = 9'b1110_0_1111;
  localparam logic [8:0] I_HALT = 9'b1111_0_0000;
  localparam logic [8:0] I_ALU  = 9'b1011_1_0101;

  branch_ctrl_unit #(.INST_W(9), .CNT_W(CNT_W), .TIMEOUT(16'd10)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .prog_base(prog_base), .inst(inst),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .flag_we(flag_we),
    .start(start), .start_addr(start_addr), .branch(branch), .target(target),
    .taken(taken), .halt(halt), .done(done), .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [7:0] base);
    go = 1'b1; prog_base = base; inst = I_NOP;
    tick();
    go = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0; prog_base = 8'h00; inst = I_JMPF;
    alu_zero = 1'b0; alu_neg = 1'b0; flag_we = 1'b0;
    #3;
    n_tests++;
    if (obs !== {6'b110000, 8'h00, 8'h00} || cycle_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_asserted: got obs=%h cnt=%0d, required obs=%h cnt=0", obs, cycle_cnt, {6'b110000, 16'h0000});
    end
    @(negedge clk); rst_n = 1'b1; inst = I_NOP;
    repeat (5) tick();
    n_tests++;
    if (obs !== {6'b110000, 8'h00, 8'h00} || cycle_cnt !== 16'd0) begin
      n_fail++; $display("FAIL idle_5cyc: got obs=%h cnt=%0d, required obs=%h cnt=0", obs, cycle_cnt, {6'b110000, 16'h0000});
    end
  endtask

  task automatic test_launch();
    go = 1'b1; prog_base = 8'h20;
    tick();
    go = 1'b0; prog_base = 8'h00;
    n_tests++;
    if (obs !== {6'b100000, 8'h20, 8'h00}) begin
      n_fail++; $display("FAIL launch: got obs=%h, required %h", obs, {6'b100000, 8'h20, 8'h00});
    end
    tick();
    n_tests++;
    if (start !== 1'b0 || halt !== 1'b0 || cycle_cnt !== 16'd0) begin
      n_fail++; $display("FAIL run_entry: got start=%b halt=%b cnt=%0d, required 0 0 0", start, halt, cycle_cnt);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_tests++;
      if (cycle_cnt !== 16'(i)) begin
        n_fail++; $display("FAIL run_count: got cnt=%0d, required %0d", cycle_cnt, i);
      end
    end
  endtask

  task automatic test_branch();
    flag_we = 1'b1; alu_zero = 1'b1;
    tick();
    inst = I_BZ3; alu_zero = 1'b0;
    #1;
    n_tests++;
    if ({branch, taken, target} !== {2'b11, 8'h30}) begin
      n_fail++; $display("FAIL bz_taken_old_flag: got b=%b t=%b tgt=%h, required 1 1 30", branch, taken, target);
    end
    tick();
    flag_we = 1'b0;
    #1;
    n_tests++;
    if ({branch, taken, target} !== {2'b10, 8'h30}) begin
      n_fail++; $display("FAIL bz_not_taken: got b=%b t=%b tgt=%h, required 1 0 30", branch, taken, target);
    end
    inst = I_JMPF;
    #1;
    n_tests++;
    if ({branch, taken, target} !== {2'b11, 8'hFF}) begin
      n_fail++; $display("FAIL jmp_ff: got b=%b t=%b tgt=%h, required 1 1 ff", branch, taken, target);
    end
    inst = I_BN2;
    #1;
    n_tests++;
    if ({branch, taken, target} !== {2'b10, 8'h20}) begin
      n_fail++; $display("FAIL bn_not_taken: got b=%b t=%b tgt=%h, required 1 0 20", branch, taken, target);
    end
    inst = I_ALU; flag_we = 1'b1; alu_neg = 1'b1;
    #1;
    n_tests++;
    if ({branch, taken, target, halt} !== {2'b00, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL non_control: got b=%b t=%b tgt=%h h=%b, required 0 0 00 0", branch, taken, target, halt);
    end
    tick();
    flag_we = 1'b0; alu_neg = 1'b0; inst = I_BN2;
    #1;
    n_tests++;
    if ({branch, taken, target} !== {2'b11, 8'h20} || cycle_cnt !== 16'd6) begin
      n_fail++; $display("FAIL bn_taken: got b=%b t=%b tgt=%h cnt=%0d, required 1 1 20 6", branch, taken, target, cycle_cnt);
    end
  endtask

  task automatic test_halt();
    inst = I_HALT;
    #1;
    n_tests++;
    if ({halt, branch, taken, done} !== 4'b1000) begin
      n_fail++; $display("FAIL halt_comb: got h=%b b=%b t=%b d=%b, required 1 0 0 0", halt, branch, taken, done);
    end
    tick();
    inst = I_JMPF;
    #1;
    n_tests++;
    if (obs !== {6'b010010, 8'h20, 8'h00} || cycle_cnt !== 16'd7) begin
      n_fail++; $display("FAIL halted: got obs=%h cnt=%0d, required %h cnt=7", obs, cycle_cnt, {6'b010010, 8'h20, 8'h00});
    end
    tick();
    n_tests++;
    if (cycle_cnt !== 16'd7 || done !== 1'b1) begin
      n_fail++; $display("FAIL halted_hold: got cnt=%0d done=%b, required 7 1", cycle_cnt, done);
    end
    go = 1'b1; prog_base = 8'h40; inst = I_NOP;
    tick();
    go = 1'b0;
    n_tests++;
    if (start !== 1'b1 || start_addr !== 8'h40) begin
      n_fail++; $display("FAIL relaunch: got start=%b addr=%h, required 1 40", start, start_addr);
    end
    tick();
    n_tests++;
    if (cycle_cnt !== 16'd0 || done !== 1'b0 || halt !== 1'b0) begin
      n_fail++; $display("FAIL relaunch_clear: got cnt=%0d done=%b halt=%b, required 0 0 0", cycle_cnt, done, halt);
    end
  endtask

  task automatic test_timeout();
    inst = I_NOP;
    repeat (9) tick();
    n_tests++;
    if (halt !== 1'b0 || timeout !== 1'b0 || cycle_cnt !== 16'd9) begin
      n_fail++; $display("FAIL pre_timeout: got h=%b to=%b cnt=%0d, required 0 0 9", halt, timeout, cycle_cnt);
    end
    tick();
    n_tests++;
    if ({halt, timeout, done} !== 3'b110 || cycle_cnt !== 16'd10 || start !== 1'b0) begin
      n_fail++; $display("FAIL timeout: got h=%b to=%b d=%b cnt=%0d st=%b, required 1 1 0 10 0", halt, timeout, done, cycle_cnt, start);
    end
    tick();
    n_tests++;
    if (cycle_cnt !== 16'd10 || timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_hold: got cnt=%0d to=%b, required 10 1", cycle_cnt, timeout);
    end
    launch(8'h50);
    repeat (9) tick();
    inst = I_HALT;
    tick();
    inst = I_NOP;
    n_tests++;
    if ({halt, timeout, done} !== 3'b101 || cycle_cnt !== 16'd10) begin
      n_fail++; $display("FAIL halt_vs_timeout: got h=%b to=%b d=%b cnt=%0d, required 1 0 1 10", halt, timeout, done, cycle_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    launch(8'h60);
    flag_we = 1'b1; alu_zero = 1'b1;
    repeat (3) tick();
    flag_we = 1'b0; alu_zero = 1'b0; inst = I_JMPF;
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== {6'b110000, 8'h00, 8'h00} || cycle_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid_run: got obs=%h cnt=%0d, required %h cnt=0", obs, cycle_cnt, {6'b110000, 16'h0000});
    end
    @(negedge clk); rst_n = 1'b1; inst = I_NOP;
    launch(8'h70);
    inst = I_BZ3;
    #1;
    n_tests++;
    if ({branch, taken, target} !== {2'b10, 8'h30} || cycle_cnt !== 16'd0) begin
      n_fail++; $display("FAIL flags_after_reset: got b=%b t=%b tgt=%h cnt=%0d, required 1 0 30 0", branch, taken, target, cycle_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_branch();
    test_halt();
    test_timeout();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
